// File: rtl/uart_tx_buffer.sv
// Purpose: byte FIFO that queues producer bytes and launches them one at a time into uart_tx.
// Latency: a write accepted into an empty idle buffer gives o_tx_dv in the cycle after the next edge.
// Backpressure: none upstream; a write to a full FIFO (with no pop that cycle) is dropped and o_overflow pulses.
// Optional stats: define UART_TX_BUF_STATS_EN to enable the saturating o_drop_count counter.
module uart_tx_buffer #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_dv,
    input  logic [7:0]               i_wr_byte,
    input  logic                     i_tx_active,
    output logic                     o_tx_dv,
    output logic [7:0]               o_tx_byte,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];
    logic            pop;
    logic            wr_en;

    // Launch controller and FIFO bookkeeping: decide pop/accept and the next register values.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Never launch while the transmitter still reports busy.
                if (count_q != '0 && !i_tx_active) begin
                    pop       = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                    timer_d   = '0;
                    state_d   = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                // If uart_tx never acknowledges, the byte is treated as sent rather than relaunched.
                if (i_tx_active) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        wr_en      = i_wr_dv && ((count_q < DEPTH_C) || pop);
        overflow_d = i_wr_dv && !wr_en;

        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
    end

    // All control state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            mem_q[wr_ptr_q] <= i_wr_byte;
        end
    end

`ifdef UART_TX_BUF_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped writes, cleared only by reset.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_d && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_drop_count = 8'h00;
`endif

    assign o_tx_dv    = tx_dv_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_level    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=16, START_TIMEOUT=8).
// Each scenario task drives stimulus and compares outputs against hand-computed values.
// Launches are logged on the falling edge so ordering and spacing can be checked afterwards.
module tb_uart_tx_buffer;

    logic       i_clk;
    logic       i_rst;
    logic       i_wr_dv;
    logic [7:0] i_wr_byte;
    logic       i_tx_active;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       o_overflow;
    logic [7:0] o_drop_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] launches [$];
    int         launch_cyc [$];

    uart_tx_buffer #(.DEPTH(16), .START_TIMEOUT(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr_dv      (i_wr_dv),
        .i_wr_byte    (i_wr_byte),
        .i_tx_active  (i_tx_active),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_tx_dv === 1'b1) begin
            launches.push_back(o_tx_byte);
            launch_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_wr_dv   = 1'b1;
        i_wr_byte = b;
        step();
        i_wr_dv   = 1'b0;
    endtask

    // Bounded wait for the next launch pulse; got=0 if it never came.
    task automatic wait_launch(output bit got);
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (o_tx_dv === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_wr_dv = 1'b0; i_wr_byte = 8'h00; i_tx_active = 1'b0;
        step(); step();
        i_rst = 1'b0;
        checks++; if (o_tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv got %b exp 0", o_tx_dv); end
        checks++; if (o_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", o_tx_byte); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", o_empty); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
        checks++; if (o_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", o_level); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
        checks++; if (o_drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count got %h exp 00", o_drop_count); end
    endtask

    task automatic test_single_byte();
        int base;
        base = launches.size();
        i_tx_active = 1'b0;
        write_byte(8'hA5);
        checks++; if (o_level !== 5'd1) begin errors++; $display("FAIL single_level_after_write got %0d exp 1", o_level); end
        checks++; if (o_tx_dv !== 1'b0) begin errors++; $display("FAIL single_no_early_launch got %b exp 0", o_tx_dv); end
        step();
        checks++; if (o_tx_dv !== 1'b1) begin errors++; $display("FAIL single_launch got %b exp 1", o_tx_dv); end
        checks++; if (o_tx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte got %h exp a5", o_tx_byte); end
        checks++; if (o_level !== 5'd0) begin errors++; $display("FAIL single_level_after_pop got %0d exp 0", o_level); end
        step();
        checks++; if (o_tx_dv !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b exp 0", o_tx_dv); end
        i_tx_active = 1'b1;
        repeat (100) step();
        i_tx_active = 1'b0;
        step(); step(); step();
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL single_empty_end got %b exp 1", o_empty); end
        checks++; if (o_tx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte_held got %h exp a5", o_tx_byte); end
        checks++; if (launches.size() !== base + 1) begin errors++; $display("FAIL single_launch_count got %0d exp %0d", launches.size() - base, 1); end
    endtask

    task automatic test_burst_busy();
        int base;
        bit got;
        base = launches.size();
        i_tx_active = 1'b1;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        step();
        checks++; if (o_level !== 5'd5) begin errors++; $display("FAIL burst_level got %0d exp 5", o_level); end
        checks++; if (launches.size() !== base) begin errors++; $display("FAIL burst_launch_while_busy got %0d exp 0", launches.size() - base); end
        for (int i = 1; i <= 5; i++) begin
            i_tx_active = 1'b0;
            wait_launch(got);
            checks++; if (!got) begin errors++; $display("FAIL burst_launch_timeout idx %0d got none exp launch", i); end
            checks++; if (o_tx_byte !== 8'(i)) begin errors++; $display("FAIL burst_order idx %0d got %h exp %h", i, o_tx_byte, 8'(i)); end
            checks++; if (o_level !== 5'(5 - i)) begin errors++; $display("FAIL burst_level_drain idx %0d got %0d exp %0d", i, o_level, 5 - i); end
            step();
            i_tx_active = 1'b1;
            repeat (3) step();
        end
        i_tx_active = 1'b0;
        step(); step(); step();
        checks++; if (launches.size() !== base + 5) begin errors++; $display("FAIL burst_launch_count got %0d exp 5", launches.size() - base); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL burst_empty_end got %b exp 1", o_empty); end
    endtask

    task automatic test_overflow_and_full_pop();
        int base;
        bit got;
        logic [7:0] exp_drop;
        logic [7:0] exp_b;
`ifdef UART_TX_BUF_STATS_EN
        exp_drop = 8'h01;
`else
        exp_drop = 8'h00;
`endif
        base = launches.size();
        i_tx_active = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", o_full); end
        checks++; if (o_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", o_level); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_no_early_pulse got %b exp 0", o_overflow); end
        write_byte(8'h50);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", o_overflow); end
        checks++; if (o_level !== 5'd16) begin errors++; $display("FAIL ovf_level_after_drop got %0d exp 16", o_level); end
        step();
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b exp 0", o_overflow); end
        checks++; if (o_drop_count !== exp_drop) begin errors++; $display("FAIL ovf_drop_count got %h exp %h", o_drop_count, exp_drop); end
        // Release the transmitter and write in the very cycle the head is popped.
        i_tx_active = 1'b0;
        write_byte(8'h3C);
        checks++; if (o_tx_dv !== 1'b1) begin errors++; $display("FAIL fullpop_launch got %b exp 1", o_tx_dv); end
        checks++; if (o_tx_byte !== 8'h40) begin errors++; $display("FAIL fullpop_head got %h exp 40", o_tx_byte); end
        checks++; if (o_level !== 5'd16) begin errors++; $display("FAIL fullpop_level got %0d exp 16", o_level); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_no_overflow got %b exp 0", o_overflow); end
        checks++; if (o_drop_count !== exp_drop) begin errors++; $display("FAIL fullpop_drop_count got %h exp %h", o_drop_count, exp_drop); end
        step();
        i_tx_active = 1'b1;
        repeat (3) step();
        for (int i = 1; i <= 16; i++) begin
            exp_b = (i == 16) ? 8'h3C : 8'h40 + 8'(i);
            i_tx_active = 1'b0;
            wait_launch(got);
            checks++; if (!got) begin errors++; $display("FAIL drain_launch_timeout idx %0d got none exp launch", i); end
            checks++; if (o_tx_byte !== exp_b) begin errors++; $display("FAIL drain_order idx %0d got %h exp %h", i, o_tx_byte, exp_b); end
            step();
            i_tx_active = 1'b1;
            repeat (3) step();
        end
        i_tx_active = 1'b0;
        repeat (5) step();
        checks++; if (launches.size() !== base + 17) begin errors++; $display("FAIL drain_launch_count got %0d exp 17", launches.size() - base); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", o_empty); end
    endtask

    task automatic test_start_timeout();
        int base;
        base = launches.size();
        i_tx_active = 1'b0;
        write_byte(8'h77);
        write_byte(8'h88);
        for (int n = 0; n < 40 && launches.size() < base + 2; n++) step();
        checks++; if (launches.size() !== base + 2) begin errors++; $display("FAIL tmo_launches got %0d exp 2", launches.size() - base); end
        if (launches.size() >= base + 2) begin
            checks++; if (launches[base] !== 8'h77) begin errors++; $display("FAIL tmo_first_byte got %h exp 77", launches[base]); end
            checks++; if (launches[base + 1] !== 8'h88) begin errors++; $display("FAIL tmo_second_byte got %h exp 88", launches[base + 1]); end
            checks++; if (launch_cyc[base + 1] - launch_cyc[base] !== 9) begin errors++; $display("FAIL tmo_spacing got %0d exp 9", launch_cyc[base + 1] - launch_cyc[base]); end
        end
        repeat (15) step();
        checks++; if (launches.size() !== base + 2) begin errors++; $display("FAIL tmo_no_relaunch got %0d exp 2", launches.size() - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit got;
        base = launches.size();
        i_tx_active = 1'b0;
        for (int i = 0; i < 5; i++) write_byte(8'hD1 + 8'(i));
        i_tx_active = 1'b1;
        step();
        checks++; if (o_level !== 5'd4) begin errors++; $display("FAIL rst_mid_level_before got %0d exp 4", o_level); end
        checks++; if (launches.size() !== base + 1) begin errors++; $display("FAIL rst_mid_launches_before got %0d exp 1", launches.size() - base); end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_tx_active = 1'b0;
        checks++; if (o_level !== 5'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", o_level); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b exp 1", o_empty); end
        checks++; if (o_tx_byte !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_byte got %h exp 00", o_tx_byte); end
        repeat (20) step();
        checks++; if (launches.size() !== base + 1) begin errors++; $display("FAIL rst_mid_no_launch got %0d exp 1", launches.size() - base); end
        write_byte(8'h5A);
        wait_launch(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_mid_relaunch_timeout got none exp launch"); end
        checks++; if (o_tx_byte !== 8'h5A) begin errors++; $display("FAIL rst_mid_new_byte got %h exp 5a", o_tx_byte); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_busy();
        test_overflow_and_full_pop();
        test_start_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and launch controller between the effect multiplexer and `uart_tx`. Every received/processed byte is queued and sent to `uart_tx` one at a time, using the `o_tx_active` busy flag, so bytes arriving while the transmitter is busy are no longer dropped. It replaces the single-slot echo state machine in the top level. Producer side: one-cycle valid strobe. Consumer side: one-cycle `tx_dv` launch pulse.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `START_TIMEOUT`, 8: cycles to wait for `i_tx_active` to rise after a launch before the byte is considered sent; ≥ 1.

Ports:
- `i_clk`  in  1: system clock; all logic on its rising edge.
- `i_rst`  in  1: reset; synchronous, active-high.
- `i_wr_dv`  in  1: one-cycle strobe; `i_wr_byte` valid.
- `i_wr_byte`  in  8: byte to queue.
- `i_tx_active`  in  1: busy flag from `uart_tx`.
- `o_tx_dv`  out  1: one-cycle launch pulse to `uart_tx`.
- `o_tx_byte`  out  8: byte to transmit; held stable until the next launch.
- `o_full`  out  1: count == DEPTH.
- `o_empty`  out  1: count == 0.
- `o_level`  out  $clog2(DEPTH)+1: current count.
- `o_overflow`  out  1: one-cycle pulse when a write is dropped.
- `o_drop_count`  out  8: saturating count of dropped writes (see Configuration).

## Operation
- Storage: DEPTH×8 array, with read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a registered count.
- **Write:**
  - A write is accepted when `i_wr_dv` is high and (count < DEPTH, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped, the array and pointers are unchanged, and `o_overflow` pulses.
- **Pop:** occurs only on a launch (below). Simultaneous accepted write and pop leaves the count unchanged.
- **FSM states:**
  - `S_IDLE`: if count > 0 and `!i_tx_active`, then pop, set `o_tx_byte` to the head entry, pulse `o_tx_dv`, clear the timer, and go to `S_WAIT_START`.
  - `S_WAIT_START`:
    - if `i_tx_active`, go to `S_WAIT_DONE`;
    - else, when the timer reaches START_TIMEOUT−1, go to `S_IDLE` (byte treated as sent, never relaunched);
    - else increment the timer.
  - `S_WAIT_DONE`: when `!i_tx_active`, go to `S_IDLE`.
- Exactly one launch per popped byte. A byte is never launched while `i_tx_active` is high in `S_IDLE`.
- **Ordering:** strict FIFO; bytes leave in write order.
- **Reset values:**
  - FSM = `S_IDLE`; pointers, count and timer = 0.
  - `o_tx_dv`=0, `o_tx_byte`=8'h00, `o_empty`=1, `o_full`=0, `o_level`=0, `o_overflow`=0, `o_drop_count`=0.
  - Array contents are don't-care.
- **Reset mid-operation:** all queued bytes are discarded. If reset coincides with a launch cycle, `o_tx_dv` is 0 the next cycle.

## Timing
- All outputs are registered.
- **Latency:** write accepted at edge N with an empty FIFO, `S_IDLE` and `i_tx_active`=0 → `o_tx_dv`=1 in the cycle after edge N+1. `o_level` reads 1 for one cycle, then 0.
- `o_tx_dv` is high for exactly one cycle; `o_tx_byte` is valid from that cycle onward.
- `o_full`, `o_empty` and `o_level` reflect the count after the previous edge.
- `o_overflow` is high in the cycle after the dropped strobe.
- **Minimum spacing between launches:** 2 cycles when the transmitter never asserts active (timeout path with START_TIMEOUT=1); otherwise it is bounded by the `i_tx_active` fall.

## Configuration
- `UART_TX_BUF_STATS_EN`:
  - **Defined:** `o_drop_count` increments on each dropped write and saturates at 8'hFF; it clears only on reset.
  - **Undefined:** no counter logic; `o_drop_count` is tied to 8'h00. All other behaviour is identical.

## Test plan
- **Single byte:** write 8'hA5 with `i_tx_active`=0 → `o_tx_dv` pulse one cycle after acceptance with `o_tx_byte`=8'hA5. Raise active 1 cycle later, drop it after 100 cycles → FSM idle, `o_empty`=1.
- **Burst while busy:** hold active=1 and write 8'h01..8'h05 → no launch, `o_level`=5. Toggle the active pulse per launch → outputs 01,02,03,04,05 in order, one `o_tx_dv` each.
- **Overflow:** DEPTH=16, active=1, write 17 bytes → `o_full`=1 after 16, one `o_overflow` pulse, `o_drop_count`=1 (macro on) / 0 (macro off). The 17th byte is never transmitted.
- **Full + simultaneous pop:** FIFO full, release active, and write 8'h3C in the launch cycle → no overflow, `o_level` stays 16, and 8'h3C is transmitted last.
- **Start timeout:** START_TIMEOUT=8, active never rises, two bytes queued → second `o_tx_dv` exactly 9 cycles after the first.
- **Reset mid-operation:** 4 bytes queued during `S_WAIT_DONE`, assert `i_rst` 1 cycle → `o_level`=0, `o_empty`=1, and no `o_tx_dv` until new writes arrive.
